stopwatch_report_parser: RTL and testbench

Host-side decoder for the stopwatch time report stream. It pops ASCII bytes from a first-word-fall-through FIFO (the tx FIFO fed by the stopwatch transmit interface) and parses fixed frames of four decimal digits followed by CR. It recovers the BCD digits d3..d0 and signals each valid frame with a one-cycle pulse. It is the receiving end of the report format and is used for loopback checking and host-side display.

---
 rtl/stopwatch_uart_pkg.sv | 26 ++
 rtl/report_idle_timer.sv | 32 +++
 rtl/stopwatch_report_parser.sv | 142 ++++++++++++++
 tb/tb_stopwatch_report_parser.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_uart_pkg.sv
// Shared constants and types for the stopwatch UART report path.
// The parser's optional error counter is enabled with STOPWATCH_PARSER_ERRCNT_EN.
package stopwatch_uart_pkg;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_9  = 8'h39;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam logic [7:0] CMD_GO     = 8'h47;  // 'G'
  localparam logic [7:0] CMD_PAUSE  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_UP     = 8'h55;  // 'U'
  localparam logic [7:0] CMD_CLR    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_REPORT = 8'h52;  // 'R'

  localparam int unsigned FRAME_DIGITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    S_D2,
    S_D1,
    S_D0,
    S_TERM
  } parser_state_e;

endpackage

// File: rtl/report_idle_timer.sv
// Idle-gap timer for the report parser: counts empty cycles inside a partial frame
// and flags expiry on the cycle the count would reach TIMEOUT.
module report_idle_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_idle,
  output logic o_expired
);

  logic [TO_W-1:0] r_cnt;
  logic            w_at_limit;

  assign w_at_limit = (r_cnt == TO_W'(TIMEOUT - 1));
  // An accepted byte in the same cycle always beats expiry.
  assign o_expired  = i_enable & i_idle & ~i_clear & w_at_limit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_expired) begin
      r_cnt <= '0;
    end else if (i_idle) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_report_parser.sv
// Parses "DDDD<CR>" report frames from a FWFT FIFO into BCD digits.
// Define STOPWATCH_PARSER_ERRCNT_EN to add the saturating o_err_cnt output.
module stopwatch_report_parser
  import stopwatch_uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_empty,
  input  logic [DBIT-1:0] i_rd_data,
  output logic            o_rd,
  output logic [3:0]      o_d3,
  output logic [3:0]      o_d2,
  output logic [3:0]      o_d1,
  output logic [3:0]      o_d0,
  output logic            o_valid,
  output logic            o_err
`ifdef STOPWATCH_PARSER_ERRCNT_EN
  ,
  output logic [7:0]      o_err_cnt
`endif
);

  parser_state_e r_state, w_state_nxt;

  logic [3:0] r_sh  [FRAME_DIGITS];
  logic [3:0] r_dig [FRAME_DIGITS];
  logic       r_valid, r_err;

  logic [7:0]              w_byte;
  logic                    w_accept, w_is_digit, w_expired;
  logic [3:0]              w_digit;
  logic [FRAME_DIGITS-1:0] w_load;
  logic                    w_commit, w_valid_nxt, w_err_nxt;

  assign w_accept   = ~i_empty;
  assign o_rd       = w_accept;
  assign w_byte     = 8'(i_rd_data);
  assign w_is_digit = (w_byte >= CHAR_0) && (w_byte <= CHAR_9);
  assign w_digit    = w_byte[3:0];

  report_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_accept),
    .i_enable  (r_state != IDLE),
    .i_idle    (i_empty),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = '0;
    w_commit    = 1'b0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        IDLE: begin
          // Anything but a digit is dropped here without complaint.
          if (w_is_digit) begin
            w_load[3]   = 1'b1;
            w_state_nxt = S_D2;
          end
        end
        S_D2, S_D1, S_D0: begin
          if (w_is_digit) begin
            unique case (r_state)
              S_D2:    begin w_load[2] = 1'b1; w_state_nxt = S_D1;   end
              S_D1:    begin w_load[1] = 1'b1; w_state_nxt = S_D0;   end
              default: begin w_load[0] = 1'b1; w_state_nxt = S_TERM; end
            endcase
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        S_TERM: begin
          if (w_byte == CHAR_CR) begin
            w_commit    = 1'b1;
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt   = 1'b1;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_expired) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < FRAME_DIGITS; i++) begin
        r_sh[i]  <= '0;
        r_dig[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      for (int i = 0; i < FRAME_DIGITS; i++) begin
        if (w_load[i]) r_sh[i] <= w_digit;
        if (w_commit)  r_dig[i] <= r_sh[i];
      end
    end
  end

  assign o_d3    = r_dig[3];
  assign o_d2    = r_dig[2];
  assign o_d1    = r_dig[1];
  assign o_d0    = r_dig[0];
  assign o_valid = r_valid;
  assign o_err   = r_err;

`ifdef STOPWATCH_PARSER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stopwatch_report_parser.sv
// Directed bench for stopwatch_report_parser: expected valid/err events are queued as
// bytes are driven and popped by a monitor whenever the DUT pulses o_valid or o_err.
module tb_stopwatch_report_parser;

  localparam int unsigned TB_TIMEOUT = 64;
  localparam logic [7:0]  CR         = 8'h0D;
  localparam logic [7:0]  LF         = 8'h0A;

  typedef struct packed {
    logic        is_err;
    logic [15:0] dig;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       i_empty;
  logic [7:0] i_rd_data;
  logic       o_rd;
  logic [3:0] o_d3, o_d2, o_d1, o_d0;
  logic       o_valid, o_err;
`ifdef STOPWATCH_PARSER_ERRCNT_EN
  logic [7:0] o_err_cnt;
`endif

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_dig = 16'h0000;

  stopwatch_report_parser #(
    .DBIT    (8),
    .TIMEOUT (TB_TIMEOUT),
    .TO_W    (7)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_empty   (i_empty),
    .i_rd_data (i_rd_data),
    .o_rd      (o_rd),
    .o_d3      (o_d3),
    .o_d2      (o_d2),
    .o_d1      (o_d1),
    .o_d0      (o_d0),
    .o_valid   (o_valid),
    .o_err     (o_err)
`ifdef STOPWATCH_PARSER_ERRCNT_EN
    ,
    .o_err_cnt (o_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {o_d3, o_d2, o_d1, o_d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each byte sits at the FIFO head for exactly one cycle, so it is popped on the next edge.
  task automatic send_byte(input logic [7:0] b);
    i_empty   = 1'b0;
    i_rd_data = b;
    #1;
    chk("rd_follows_empty", {31'd0, o_rd}, 32'd1);
    @(posedge clk);
    #1;
    i_empty = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    i_empty = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_valid(input logic [15:0] d);
    cur_dig = d;
    exp_q.push_back('{is_err: 1'b0, dig: d});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, dig: cur_dig});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cur_dig = 16'h0000;
    #1;
    chk("reset_digits", {16'd0, digits()}, 32'h0000);
    chk("reset_pulses", {30'd0, o_valid, o_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_err)) begin
      ev_t e;
      checks++;
      assert (!(o_valid && o_err))
      else begin
        errors++;
        $error("FAIL both_pulses observed valid=%0b err=%0b expected one", o_valid, o_err);
      end
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_event observed valid=%0b err=%0b expected none", o_valid,
               o_err);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (o_err === e.is_err)
        else begin
          errors++;
          $error("FAIL event_kind observed err=%0b expected err=%0b", o_err, e.is_err);
        end
        checks++;
        assert (digits() === e.dig)
        else begin
          errors++;
          $error("FAIL event_digits observed %04h expected %04h", digits(), e.dig);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    i_empty   = 1'b1;
    i_rd_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", {16'd0, digits()}, 32'h0000);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_err", {31'd0, o_err}, 32'd0);
    chk("reset_rd", {31'd0, o_rd}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back frame.
    expect_valid(16'h1234);
    send_str("1234");
    send_byte(CR);
    chk("frame1_digits", {16'd0, digits()}, 32'h1234);
    chk("frame1_valid", {31'd0, o_valid}, 32'd1);
    idle(2);
    chk("frame1_drain", exp_q.size(), 0);

    // Leading CR/LF are ignored in IDLE.
    expect_valid(16'h0059);
    send_byte(LF);
    send_byte(CR);
    send_str("0059");
    send_byte(CR);
    send_byte(LF);
    idle(2);
    chk("crlf_digits", {16'd0, digits()}, 32'h0059);
    chk("crlf_drain", exp_q.size(), 0);

    // 'a' aborts the frame; '9' then restarts one that CR aborts in S_D2.
    pulse_reset();
    expect_err();
    expect_err();
    send_str("12a9");
    send_byte(CR);
    idle(1);
    chk("bad_frame_digits", {16'd0, digits()}, 32'h0000);
    expect_valid(16'h0007);
    send_str("0007");
    send_byte(CR);
    idle(2);
    chk("recover_digits", {16'd0, digits()}, 32'h0007);
    chk("bad_drain", exp_q.size(), 0);

    // Timeout fires after exactly TIMEOUT empty cycles.
    expect_err();
    send_str("98");
    idle(TB_TIMEOUT - 1);
    chk("timeout_early", {31'd0, o_err}, 32'd0);
    idle(1);
    chk("timeout_pulse", {31'd0, o_err}, 32'd1);
    idle(1);
    chk("timeout_single", {31'd0, o_err}, 32'd0);
    // "76" starts a fresh frame that CR then aborts in S_D1.
    expect_err();
    send_str("76");
    send_byte(CR);
    idle(2);
    chk("timeout_digits", {16'd0, digits()}, 32'h0007);
    chk("timeout_drain", exp_q.size(), 0);

    // A byte arriving on the expiry cycle wins.
    expect_valid(16'h1357);
    send_str("13");
    idle(TB_TIMEOUT - 1);
    send_str("57");
    send_byte(CR);
    idle(2);
    chk("byte_wins_digits", {16'd0, digits()}, 32'h1357);
    chk("byte_wins_drain", exp_q.size(), 0);

    // Reset mid-frame clears outputs and discards the partial frame.
    expect_valid(16'h4321);
    send_str("4321");
    send_byte(CR);
    send_str("55");
    pulse_reset();
    expect_valid(16'h0100);
    send_str("0100");
    send_byte(CR);
    idle(2);
    chk("post_reset_digits", {16'd0, digits()}, 32'h0100);
    chk("post_reset_drain", exp_q.size(), 0);

`ifdef STOPWATCH_PARSER_ERRCNT_EN
    pulse_reset();
    chk("errcnt_reset", {24'd0, o_err_cnt}, 32'd0);
    for (int i = 0; i < 300; i++) begin
      expect_err();
      send_str("5x");
      if (i == 0)   chk("errcnt_one", {24'd0, o_err_cnt}, 32'd1);
      if (i == 253) chk("errcnt_254", {24'd0, o_err_cnt}, 32'd254);
      if (i == 254) chk("errcnt_255", {24'd0, o_err_cnt}, 32'd255);
    end
    idle(2);
    chk("errcnt_saturated", {24'd0, o_err_cnt}, 32'd255);
    chk("errcnt_drain", exp_q.size(), 0);
`endif

    idle(2);
    chk("final_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
